// File: rtl/forest_pkg.sv
// Shared defaults, width helpers, FSM encoding and vote-bit indexing for the forest vote accumulator.
// No logic; latency and backpressure live in the modules that import it.
package forest_pkg;

    localparam int NUM_CLASSES_DEF = 3;
    localparam int NUM_TREES_DEF   = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_DECIDE = 2'd2,
        ST_OUT    = 2'd3
    } state_t;

    function automatic int cnt_width(input int num_trees);
        return $clog2(num_trees + 1);
    endfunction

    function automatic int cls_width(input int num_classes);
        return (num_classes < 2) ? 1 : $clog2(num_classes);
    endfunction

    // Position of tree t's vote for class c inside the flat vote vector.
    function automatic int vote_idx(input int c, input int t, input int num_trees);
        return c * num_trees + t;
    endfunction

endpackage

// File: rtl/forest_vote_argmax_step.sv
// One step of the serial argmax: folds cnt_k into the running best count/class/tie.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the step result is registered.
module forest_vote_argmax_step #(
    parameter int CNT_W = 3,
    parameter int CLS_W = 2
) (
    input  logic [CNT_W-1:0] cnt_k,
    input  logic [CLS_W-1:0] k,
    input  logic [CNT_W-1:0] best_cnt,
    input  logic [CLS_W-1:0] best_cls,
    input  logic             best_tie,
    output logic [CNT_W-1:0] nxt_cnt,
    output logic [CLS_W-1:0] nxt_cls,
    output logic             nxt_tie
);

    // Strict greater-than keeps the lowest class index on equal counts.
    always_comb begin
        nxt_cnt = best_cnt;
        nxt_cls = best_cls;
        nxt_tie = best_tie;
        if (cnt_k > best_cnt) begin
            nxt_cnt = cnt_k;
            nxt_cls = k;
            nxt_tie = 1'b0;
        end else if ((cnt_k == best_cnt) && (cnt_k != '0)) begin
            nxt_tie = 1'b1;
        end
    end

endmodule

// File: rtl/forest_vote_accum.sv
// Captures a vote vector, tallies per-class votes one tree per cycle, then serially picks the winner.
// Latency: out_valid rises NUM_TREES+NUM_CLASSES edges after acceptance.
// Backpressure: single in flight; in_ready low until the result is taken via out_valid&&out_ready.
module forest_vote_accum
    import forest_pkg::*;
#(
    parameter  int NUM_CLASSES = NUM_CLASSES_DEF,
    parameter  int NUM_TREES   = NUM_TREES_DEF,
    localparam int CNT_W       = cnt_width(NUM_TREES),
    localparam int CLS_W       = cls_width(NUM_CLASSES)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_CLASSES*NUM_TREES-1:0] in_votes,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [CLS_W-1:0]                 out_class,
    output logic [CNT_W-1:0]                 out_count,
    output logic                             out_tie,
    output logic                             out_none
);

    localparam int               T_W    = (NUM_TREES > 1) ? $clog2(NUM_TREES) : 1;
    localparam logic [T_W-1:0]   T_LAST = T_W'(NUM_TREES - 1);
    localparam logic [CLS_W-1:0] K_LAST = CLS_W'(NUM_CLASSES - 1);

    state_t state, state_nxt;

    logic [NUM_CLASSES*NUM_TREES-1:0]   vote_q;
    logic [NUM_CLASSES-1:0][CNT_W-1:0]  cnt;
    logic [NUM_CLASSES-1:0]             cur_votes;
    logic [T_W-1:0]                     t;
    logic [CLS_W-1:0]                   k;
    logic [CNT_W-1:0]                   best_cnt;
    logic [CLS_W-1:0]                   best_cls;
    logic                               best_tie;
    logic [CNT_W-1:0]                   nxt_cnt;
    logic [CLS_W-1:0]                   nxt_cls;
    logic                               nxt_tie;

    // Column t of the captured vector: one vote per class.
    for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_row
        logic [NUM_TREES-1:0] row;
        assign row          = vote_q[vote_idx(c, 0, NUM_TREES) +: NUM_TREES];
        assign cur_votes[c] = row[t];
    end

    forest_vote_argmax_step #(
        .CNT_W (CNT_W),
        .CLS_W (CLS_W)
    ) u_argmax_step (
        .cnt_k    (cnt[k]),
        .k        (k),
        .best_cnt (best_cnt),
        .best_cls (best_cls),
        .best_tie (best_tie),
        .nxt_cnt  (nxt_cnt),
        .nxt_cls  (nxt_cls),
        .nxt_tie  (nxt_tie)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (in_valid)    state_nxt = ST_COUNT;
            ST_COUNT:  if (t == T_LAST) state_nxt = ST_DECIDE;
            ST_DECIDE: if (k == K_LAST) state_nxt = ST_OUT;
            ST_OUT:    if (out_ready)   state_nxt = ST_IDLE;
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_OUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vote_q    <= '0;
            cnt       <= '0;
            t         <= '0;
            k         <= '0;
            best_cnt  <= '0;
            best_cls  <= '0;
            best_tie  <= 1'b0;
            out_class <= '0;
            out_count <= '0;
            out_tie   <= 1'b0;
            out_none  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        vote_q <= in_votes;
                        cnt    <= '0;
                        t      <= '0;
                    end
                end
                ST_COUNT: begin
                    for (int c = 0; c < NUM_CLASSES; c++) begin
                        cnt[c] <= cnt[c] + CNT_W'(cur_votes[c]);
                    end
                    if (t == T_LAST) begin
                        k        <= '0;
                        best_cnt <= '0;
                        best_cls <= '0;
                        best_tie <= 1'b0;
                    end else begin
                        t <= t + 1'b1;
                    end
                end
                ST_DECIDE: begin
                    best_cnt <= nxt_cnt;
                    best_cls <= nxt_cls;
                    best_tie <= nxt_tie;
                    if (k == K_LAST) begin
                        out_count <= nxt_cnt;
                        out_none  <= (nxt_cnt == '0);
                        out_class <= (nxt_cnt == '0) ? '0 : nxt_cls;
                        out_tie   <= (nxt_cnt == '0) ? 1'b0 : nxt_tie;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_forest_vote_accum.sv
// Directed plus random checks of forest_vote_accum against a popcount/argmax reference model.
module tb_forest_vote_accum;

    localparam int NC = 3;
    localparam int NT = 5;
    localparam int VW = NC * NT;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [VW-1:0] in_votes = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [1:0]    out_class;
    logic [2:0]    out_count;
    logic          out_tie;
    logic          out_none;

    int errors = 0;
    int checks = 0;

    forest_vote_accum #(.NUM_CLASSES(NC), .NUM_TREES(NT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_votes  (in_votes),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_count (out_count),
        .out_tie   (out_tie),
        .out_none  (out_none)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: popcount per class, lowest index among the maxima, tie if the max is shared and nonzero.
    task automatic model(input logic [VW-1:0] v, output int cls, output int cnt,
                         output int tie, output int none);
        int cnts [NC];
        int mx;
        int n_at_max;
        mx = 0;
        for (int c = 0; c < NC; c++) begin
            cnts[c] = $countones(v[c*NT +: NT]);
            if (cnts[c] > mx) mx = cnts[c];
        end
        cls = 0;
        n_at_max = 0;
        for (int c = NC - 1; c >= 0; c--) begin
            if (cnts[c] == mx) begin
                cls = c;
                n_at_max++;
            end
        end
        cnt  = mx;
        none = (mx == 0) ? 1 : 0;
        tie  = (mx > 0 && n_at_max > 1) ? 1 : 0;
        if (mx == 0) cls = 0;
    endtask

    task automatic check_result(input string tag, input logic [VW-1:0] v);
        int e_cls, e_cnt, e_tie, e_none;
        model(v, e_cls, e_cnt, e_tie, e_none);
        chk({tag, "_class"}, int'(out_class), e_cls);
        chk({tag, "_count"}, int'(out_count), e_cnt);
        chk({tag, "_tie"},   int'(out_tie),   e_tie);
        chk({tag, "_none"},  int'(out_none),  e_none);
    endtask

    // Accepts v, measures latency, optionally churns inputs, stalls, then completes the handshake.
    task automatic run_vec(input string tag, input logic [VW-1:0] v,
                           input bit churn, input int stall, input bit full);
        int lat;
        @(negedge clk);
        if (full) chk({tag, "_in_ready_idle"}, int'(in_ready), 1);
        in_votes = v;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (churn) in_votes = VW'($urandom);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, lat, NT + NC);
        check_result(tag, v);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            in_votes = VW'($urandom);
            @(posedge clk);
            @(negedge clk);
            if (full || i == stall - 1) begin
                chk({tag, "_stall_valid"}, int'(out_valid), 1);
                chk({tag, "_stall_in_ready"}, int'(in_ready), 0);
                check_result({tag, "_stall"}, v);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_drop_valid"}, int'(out_valid), 0);
        chk({tag, "_back_idle"}, int'(in_ready), 1);
    endtask

    initial begin
        logic [VW-1:0] v;
        #1;
        chk("rst_in_ready",  int'(in_ready),  1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_class", int'(out_class), 0);
        chk("rst_out_count", int'(out_count), 0);
        chk("rst_out_tie",   int'(out_tie),   0);
        chk("rst_out_none",  int'(out_none),  0);
        @(negedge clk);
        rst_n = 1'b1;

        v = {5'b00001, 5'b11111, 5'b00011};
        run_vec("clear_winner", v, 1'b0, 0, 1'b1);
        v = {5'b10101, 5'b00000, 5'b00111};
        run_vec("tie", v, 1'b0, 0, 1'b1);
        run_vec("no_votes", '0, 1'b0, 0, 1'b1);
        v = {5'b01100, 5'b11011, 5'b10000};
        run_vec("backpressure", v, 1'b0, 10, 1'b1);
        v = {5'b11000, 5'b00001, 5'b01110};
        run_vec("churn", v, 1'b1, 0, 1'b1);

        // out_ready pulse with nothing pending must be a no-op.
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("stray_ready_valid", int'(out_valid), 0);
        chk("stray_ready_in_ready", int'(in_ready), 1);
        chk("stray_ready_count_held", int'(out_count), 3);

        // Reset in the middle of the tally.
        @(negedge clk);
        in_votes = {5'b11111, 5'b11111, 5'b11111};
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre_reset_busy", int'(in_ready), 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready",  int'(in_ready),  1);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_count", int'(out_count), 0);
        chk("midrst_out_class", int'(out_class), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("postrst_out_valid", int'(out_valid), 0);
        v = {5'b00110, 5'b00100, 5'b11101};
        run_vec("after_reset", v, 1'b0, 0, 1'b1);

        for (int i = 0; i < 25; i++) begin
            v = VW'($urandom);
            run_vec("random", v, bit'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
